// File: rtl/clock_pkg.sv
// Shared definitions for the clock digit sequencer: digit/field/op/state
// encodings, per-digit roll-over limits and small index helpers.
package clock_pkg;

    // Digit order is also the ripple order: a carry/borrow moves to index+1.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        M0 = 3'd2,
        M1 = 3'd3,
        H0 = 3'd4,
        H1 = 3'd5
    } digit_e;

    typedef enum logic [1:0] {
        SEC  = 2'd0,
        MIN  = 2'd1,
        HOUR = 2'd2,
        NONE = 2'd3
    } field_e;

    typedef enum logic {
        INC = 1'b0,
        DEC = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HFIX = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 6;

    localparam logic [3:0] LIM_S0    = 4'd9;
    localparam logic [3:0] LIM_S1    = 4'd5;
    localparam logic [3:0] LIM_M0    = 4'd9;
    localparam logic [3:0] LIM_M1    = 4'd5;
    localparam logic [3:0] LIM_H0    = 4'd9;
    localparam logic [3:0] LIM_H0_HI = 4'd3;  // h0 ceiling while h1 = 2
    localparam logic [3:0] LIM_H1    = 4'd2;

    // Largest legal value of a digit; h0 depends on the current tens-of-hours.
    function automatic logic [3:0] digit_limit(input digit_e idx, input logic [3:0] h1);
        logic [3:0] lim;
        case (idx)
            S0:      lim = LIM_S0;
            S1:      lim = LIM_S1;
            M0:      lim = LIM_M0;
            M1:      lim = LIM_M1;
            H0:      lim = (h1 == LIM_H1) ? LIM_H0_HI : LIM_H0;
            H1:      lim = LIM_H1;
            default: lim = 4'd0;
        endcase
        return lim;
    endfunction

    // Units digit of a field; the tens digit is always the next index.
    function automatic digit_e field_start(input field_e f);
        digit_e d;
        case (f)
            SEC:     d = S0;
            MIN:     d = M0;
            HOUR:    d = H0;
            default: d = S0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/digit_step_unit.sv
// Combinational single-digit +1/-1 with wrap flag. One instance is shared by
// every request; the sequencer presents one digit per cycle.
module digit_step_unit
    import clock_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [3:0] limit,
    input  op_e        op,
    output logic [3:0] next,
    output logic       wrap
);

    // Increment wraps at the limit, decrement wraps at zero back to the limit.
    // A digit above its limit (h0 briefly after an hours borrow) is treated as
    // being at the limit so it still wraps cleanly.
    always_comb begin
        next = digit;
        wrap = 1'b0;
        if (op == INC) begin
            if (digit >= limit) begin
                next = 4'd0;
                wrap = 1'b1;
            end else begin
                next = digit + 4'd1;
            end
        end else begin
            if (digit == 4'd0) begin
                next = limit;
                wrap = 1'b1;
            end else begin
                next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_digit_sequencer.sv
// HH:MM:SS time-keeping controller. Latches tick and button requests, then
// ripples +1/-1 through the BCD digits one digit per cycle using a single
// shared digit step unit. Hours are clamped to 23 after any ripple into h1.
module clock_digit_sequencer
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       run_en,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [1:0] sel_field,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       busy,
    output logic       done,
    output logic       tick_overrun,
    output logic       btn_drop
);

    // Time digits, indexed by digit_e.
    logic [3:0] digit_reg [NUM_DIGITS];

    // Sequencer state
    state_e     state_reg;
    digit_e     cur_reg;
    digit_e     stop_reg;
    op_e        op_reg;

    // Pending request latches
    logic       tick_pend_reg;
    logic       btn_pend_reg;
    op_e        btn_op_reg;
    field_e     btn_field_reg;

    // Registered status outputs
    logic       busy_reg;
    logic       done_reg;
    logic       tick_overrun_reg;
    logic       btn_drop_reg;

    // Combinational helpers
    field_e     sel_f;
    logic       tick_req;
    logic       btn_req;
    op_e        btn_req_op;
    logic       accept_tick;
    logic       accept_btn;
    digit_e     btn_start;
    logic [3:0] cur_value;
    logic [3:0] cur_limit;
    logic [3:0] step_next;
    logic       step_wrap;
    logic       hfix_clamp;
    logic [NUM_DIGITS-1:0] digit_we;
    logic [3:0] digit_wdata [NUM_DIGITS];

    assign sel_f       = field_e'(sel_field);
    assign tick_req    = tick & run_en;
    // Simultaneous inc and dec cancel; field NONE disables the buttons.
    assign btn_req     = (btn_inc ^ btn_dec) & (sel_f != NONE);
    assign btn_req_op  = btn_inc ? INC : DEC;
    // Tick has priority over a pending button; the loser stays latched.
    assign accept_tick = (state_reg == IDLE) & tick_pend_reg;
    assign accept_btn  = (state_reg == IDLE) & ~tick_pend_reg & btn_pend_reg;
    assign btn_start   = field_start(btn_field_reg);

    assign cur_value   = digit_reg[cur_reg];
    assign cur_limit   = digit_limit(cur_reg, digit_reg[H1]);
    assign hfix_clamp  = (state_reg == HFIX) && (digit_reg[H1] == LIM_H1)
                         && (digit_reg[H0] > LIM_H0_HI);

    digit_step_unit u_step (
        .digit (cur_value),
        .limit (cur_limit),
        .op    (op_reg),
        .next  (step_next),
        .wrap  (step_wrap)
    );

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            // Each digit is written by the step unit when it is the current
            // digit; h0 additionally takes the 23-hour clamp in HFIX.
            assign digit_we[gi] = ((state_reg == STEP) && (cur_reg == digit_e'(3'(gi))))
                                  || ((gi == int'(H0)) && hfix_clamp);
            assign digit_wdata[gi] = (state_reg == HFIX) ? LIM_H0_HI : step_next;

            // Digit storage register
            always_ff @(posedge clk) begin
                if (reset) begin
                    digit_reg[gi] <= 4'd0;
                end else if (digit_we[gi]) begin
                    digit_reg[gi] <= digit_wdata[gi];
                end
            end
        end
    endgenerate

    // Request latching, arbitration and the IDLE/STEP/HFIX sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            cur_reg          <= S0;
            stop_reg         <= S0;
            op_reg           <= INC;
            tick_pend_reg    <= 1'b0;
            btn_pend_reg     <= 1'b0;
            btn_op_reg       <= INC;
            btn_field_reg    <= SEC;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            tick_overrun_reg <= 1'b0;
            btn_drop_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            // A new pulse in the accept cycle simply re-arms the latch.
            tick_overrun_reg <= tick_req & tick_pend_reg & ~accept_tick;
            if (accept_tick) begin
                tick_pend_reg <= tick_req;
            end else if (tick_req) begin
                tick_pend_reg <= 1'b1;
            end

            // A button arriving while one is held is dropped; the held one stays.
            btn_drop_reg <= btn_req & btn_pend_reg & ~accept_btn;
            if (accept_btn) begin
                btn_pend_reg <= btn_req;
            end
            if (btn_req && (accept_btn || !btn_pend_reg)) begin
                btn_pend_reg  <= 1'b1;
                btn_op_reg    <= btn_req_op;
                btn_field_reg <= sel_f;
            end

            case (state_reg)
                IDLE: begin
                    if (accept_tick) begin
                        cur_reg   <= S0;
                        stop_reg  <= H1;
                        op_reg    <= INC;
                        state_reg <= STEP;
                        busy_reg  <= 1'b1;
                    end else if (accept_btn) begin
                        cur_reg   <= btn_start;
                        stop_reg  <= digit_e'(btn_start + 3'd1);
                        op_reg    <= btn_op_reg;
                        state_reg <= STEP;
                        busy_reg  <= 1'b1;
                    end
                end
                STEP: begin
                    if (step_wrap && (cur_reg != stop_reg)) begin
                        cur_reg <= digit_e'(cur_reg + 3'd1);
                    end else if (cur_reg == H1) begin
                        state_reg <= HFIX;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                HFIX: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ss           = {digit_reg[S1], digit_reg[S0]};
    assign mm           = {digit_reg[M1], digit_reg[M0]};
    assign hh           = {digit_reg[H1], digit_reg[H0]};
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign tick_overrun = tick_overrun_reg;
    assign btn_drop     = btn_drop_reg;

endmodule
